// File: rtl/ddr3_bm_pkg.sv
// ---------------------------------------------------------------------------
// ddr3_bm_pkg
// Shared definitions for the DDR3 burst master: FSM state encoding, the
// maximum burst length and the widths derived from it.
// Ports: none (package).
// ---------------------------------------------------------------------------
package ddr3_bm_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_ISSUE = 2'd2
  } bm_state_t;

  // Longest burst a client may request, in beats.
  localparam int MAX_BURST_LEN = 64;
  // Width of cmd_len / local_size / beat counters (holds 0..MAX_BURST_LEN).
  localparam int LEN_W = $clog2(MAX_BURST_LEN + 1);
  // Width of the read-error counter.
  localparam int ERR_CNT_W = 16;

endpackage

// File: rtl/ddr3_bm_len_fifo.sv
// ---------------------------------------------------------------------------
// ddr3_bm_len_fifo
// Small synchronous first-word-fall-through FIFO holding the burst length of
// every read command issued to the controller, so returning beats can be
// framed into commands (rd_last).
// Ports:
//   clk, srst        - clock and synchronous active-high reset
//   push, push_data  - write one length (ignored when full)
//   pop              - drop the head entry (ignored when empty)
//   head             - current head entry, valid while !empty
//   full, empty      - occupancy flags
// ---------------------------------------------------------------------------
module ddr3_bm_len_fifo
  import ddr3_bm_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = LEN_W
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_ok, pop_ok;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem_reg[rd_ptr_reg];

  // Entries are cleared on reset so a stale length can never reappear.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (srst) begin
        mem_reg[gi] <= '0;
      end else if (push_ok && (wr_ptr_reg == PTR_W'(gi))) begin
        mem_reg[gi] <= push_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/ddr3_burst_master.sv
// ---------------------------------------------------------------------------
// ddr3_burst_master
// Converts client burst commands into DDR3 controller local_* requests.
// Writes stream beats straight through; reads issue one request and the
// returning beats are framed with rd_last using a length FIFO. Outstanding
// read beats are bounded by MAX_RD_BEATS, outstanding commands by
// LEN_FIFO_DEPTH.
// Ports:
//   phy_clk, phy_reset                 - clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/len     - client command (len 1..64, 0 = drop)
//   wr_valid/ready/data/be             - client write beats
//   rd_valid/last/data                 - client read beats
//   local_address/size/read_req/write_req/burstbegin/wdata/be - to controller
//   local_ready/init_done/rdata_valid/rdata_error/rdata       - from controller
//   err_cnt                            - read-error beat count
// Build option: define DDR3_BURST_MASTER_ERRCNT_EN to enable the saturating
// err_cnt counter; otherwise err_cnt is constant zero.
// ---------------------------------------------------------------------------
module ddr3_burst_master
  import ddr3_bm_pkg::*;
#(
  parameter int ADDR_W         = 25,
  parameter int DATA_W         = 128,
  parameter int MAX_RD_BEATS   = 128,
  parameter int LEN_FIFO_DEPTH = 8
) (
  input  logic                 phy_clk,
  input  logic                 phy_reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDR_W-1:0]    cmd_addr,
  input  logic [LEN_W-1:0]     cmd_len,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic [DATA_W/8-1:0]  wr_be,
  output logic                 rd_valid,
  output logic                 rd_last,
  output logic [DATA_W-1:0]    rd_data,
  output logic [ADDR_W-1:0]    local_address,
  output logic [LEN_W-1:0]     local_size,
  output logic                 local_read_req,
  output logic                 local_write_req,
  output logic                 local_burstbegin,
  output logic [DATA_W-1:0]    local_wdata,
  output logic [DATA_W/8-1:0]  local_be,
  input  logic                 local_ready,
  input  logic                 local_init_done,
  input  logic                 local_rdata_valid,
  input  logic                 local_rdata_error,
  input  logic [DATA_W-1:0]    local_rdata,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int OUT_W = $clog2(MAX_RD_BEATS + 1);

  bm_state_t         state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [LEN_W-1:0]  len_reg, len_next;
  logic [LEN_W-1:0]  cnt_reg, cnt_next;
  logic              first_reg, first_next;
  logic [OUT_W-1:0]  outstanding_reg;
  logic [LEN_W-1:0]  rcnt_reg;

  logic              rd_accept;
  logic              rd_room;
  logic              fifo_full, fifo_empty;
  logic [LEN_W-1:0]  fifo_head;

  assign local_address = addr_reg;
  assign local_size    = len_reg;
  assign rd_accept     = (state_reg == RD_ISSUE) && local_ready;
  assign rd_room       = (32'(outstanding_reg) + 32'(cmd_len)) <= 32'(MAX_RD_BEATS);

  // Beats with no command waiting for them are dropped, never forwarded.
  assign rd_valid = local_rdata_valid && !fifo_empty;
  assign rd_data  = local_rdata;
  assign rd_last  = rd_valid && ((rcnt_reg + LEN_W'(1)) == fifo_head);

  ddr3_bm_len_fifo #(
    .DEPTH (LEN_FIFO_DEPTH),
    .WIDTH (LEN_W)
  ) u_len_fifo (
    .clk       (phy_clk),
    .srst      (phy_reset),
    .push      (rd_accept),
    .push_data (len_reg),
    .pop       (rd_last),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge phy_clk) begin
    if (phy_reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    addr_next        = addr_reg;
    len_next         = len_reg;
    cnt_next         = cnt_reg;
    first_next       = first_reg;
    cmd_ready        = 1'b0;
    wr_ready         = 1'b0;
    local_read_req   = 1'b0;
    local_write_req  = 1'b0;
    local_burstbegin = 1'b0;
    local_wdata      = '0;
    local_be         = '0;

    case (state_reg)
      IDLE: begin
        // Writes are never throttled here; reads need beat and FIFO room.
        cmd_ready = !phy_reset && local_init_done &&
                    (cmd_write || (rd_room && !fifo_full));
        if (cmd_valid && cmd_ready && (cmd_len != '0)) begin
          addr_next = cmd_addr;
          len_next  = cmd_len;
          if (cmd_write) begin
            state_next = WR_BURST;
            cnt_next   = cmd_len;
            first_next = 1'b1;
          end else begin
            state_next = RD_ISSUE;
          end
        end
      end

      WR_BURST: begin
        local_write_req  = wr_valid;
        local_wdata      = wr_data;
        local_be         = wr_be;
        wr_ready         = local_ready;
        local_burstbegin = wr_valid && first_reg;
        if (wr_valid && local_ready) begin
          cnt_next   = cnt_reg - LEN_W'(1);
          first_next = 1'b0;
          if (cnt_reg == LEN_W'(1)) begin
            state_next = IDLE;
          end
        end
      end

      RD_ISSUE: begin
        local_read_req   = 1'b1;
        local_burstbegin = 1'b1;
        if (local_ready) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge phy_clk) begin
    if (phy_reset) begin
      addr_reg        <= '0;
      len_reg         <= '0;
      cnt_reg         <= '0;
      first_reg       <= 1'b0;
      outstanding_reg <= '0;
      rcnt_reg        <= '0;
    end else begin
      addr_reg  <= addr_next;
      len_reg   <= len_next;
      cnt_reg   <= cnt_next;
      first_reg <= first_next;
      // Issue and return may coincide; both adjustments apply together.
      outstanding_reg <= outstanding_reg
                         + (rd_accept ? OUT_W'(len_reg) : '0)
                         - (rd_valid ? OUT_W'(1) : '0);
      if (rd_last) begin
        rcnt_reg <= '0;
      end else if (rd_valid) begin
        rcnt_reg <= rcnt_reg + LEN_W'(1);
      end
    end
  end

`ifdef DDR3_BURST_MASTER_ERRCNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_reg;

  always_ff @(posedge phy_clk) begin
    if (phy_reset) begin
      err_cnt_reg <= '0;
    end else if (local_rdata_valid && local_rdata_error && (err_cnt_reg != '1)) begin
      err_cnt_reg <= err_cnt_reg + 1'b1;
    end
  end

  assign err_cnt = err_cnt_reg;
`else
  logic unused_rdata_error;
  assign unused_rdata_error = local_rdata_error;
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_ddr3_burst_master.sv
// ---------------------------------------------------------------------------
// tb_ddr3_burst_master
// Directed self-checking bench for ddr3_burst_master (default parameters).
// Expected write beats and read return beats are queued when driven and
// compared when the DUT presents them.
// ---------------------------------------------------------------------------
module tb_ddr3_burst_master;

  logic         phy_clk;
  logic         phy_reset;
  logic         cmd_valid, cmd_ready, cmd_write;
  logic [24:0]  cmd_addr;
  logic [6:0]   cmd_len;
  logic         wr_valid, wr_ready;
  logic [127:0] wr_data;
  logic [15:0]  wr_be;
  logic         rd_valid, rd_last;
  logic [127:0] rd_data;
  logic [24:0]  local_address;
  logic [6:0]   local_size;
  logic         local_read_req, local_write_req, local_burstbegin;
  logic [127:0] local_wdata;
  logic [15:0]  local_be;
  logic         local_ready, local_init_done, local_rdata_valid, local_rdata_error;
  logic [127:0] local_rdata;
  logic [15:0]  err_cnt;

  ddr3_burst_master dut (
    .phy_clk           (phy_clk),
    .phy_reset         (phy_reset),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_write         (cmd_write),
    .cmd_addr          (cmd_addr),
    .cmd_len           (cmd_len),
    .wr_valid          (wr_valid),
    .wr_ready          (wr_ready),
    .wr_data           (wr_data),
    .wr_be             (wr_be),
    .rd_valid          (rd_valid),
    .rd_last           (rd_last),
    .rd_data           (rd_data),
    .local_address     (local_address),
    .local_size        (local_size),
    .local_read_req    (local_read_req),
    .local_write_req   (local_write_req),
    .local_burstbegin  (local_burstbegin),
    .local_wdata       (local_wdata),
    .local_be          (local_be),
    .local_ready       (local_ready),
    .local_init_done   (local_init_done),
    .local_rdata_valid (local_rdata_valid),
    .local_rdata_error (local_rdata_error),
    .local_rdata       (local_rdata),
    .err_cnt           (err_cnt)
  );

  initial phy_clk = 1'b0;
  always #5 phy_clk = ~phy_clk;

  typedef struct packed {
    logic         valid;
    logic         last;
    logic [127:0] data;
  } rd_exp_t;

  int           n_checks = 0;
  int           n_errors = 0;
  rd_exp_t      rd_sb[$];     // expected read-side outputs
  logic [143:0] wr_sb[$];     // expected {be, data} write beats
  int           m_lens[$];    // reference copy of issued read lengths
  int           m_cnt = 0;    // beats already returned for m_lens[0]

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge phy_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // One write-beat cycle in WR_BURST; new_data starts a new beat, otherwise
  // the previous (stalled) beat is held.
  task automatic wr_beat(input bit new_data, input logic bb_exp,
                         input logic [24:0] exp_addr, input logic [6:0] exp_size);
    logic [143:0] e;
    if (new_data) begin
      wr_data = {$urandom, $urandom, $urandom, $urandom};
      wr_be   = 16'($urandom);
      wr_sb.push_back({wr_be, wr_data});
    end
    wr_valid = 1'b1;
    settle();
    e = wr_sb[0];
    chk("wr_req", local_write_req, 1'b1);
    chk("wr_rd_req", local_read_req, 1'b0);
    chk("wr_burstbegin", local_burstbegin, bb_exp);
    chk("wr_ready", wr_ready, local_ready);
    chk("wr_wdata", local_wdata, e[127:0]);
    chk("wr_be", local_be, e[143:128]);
    chk("wr_addr", local_address, exp_addr);
    chk("wr_size", local_size, exp_size);
    chk("wr_cmd_ready", cmd_ready, 1'b0);
    if (local_ready) void'(wr_sb.pop_front());
    tick();
  endtask

  // Accepts a read command and completes its issue cycle with local_ready=1.
  task automatic issue_read(input logic [24:0] addr, input logic [6:0] len);
    local_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = addr;
    cmd_len   = len;
    settle();
    chk("rd_cmd_ready", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    settle();
    chk("rd_req", local_read_req, 1'b1);
    chk("rd_wr_req", local_write_req, 1'b0);
    chk("rd_burstbegin", local_burstbegin, 1'b1);
    chk("rd_size", local_size, len);
    chk("rd_addr", local_address, addr);
    m_lens.push_back(int'(len));
    tick();
  endtask

  // One controller return beat, compared against the reference framing.
  task automatic ret_beat(input logic err, output logic obs_last);
    rd_exp_t e;
    logic [127:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    local_rdata_valid = 1'b1;
    local_rdata_error = err;
    local_rdata       = d;
    if (m_lens.size() == 0) begin
      e.valid = 1'b0;
      e.last  = 1'b0;
      e.data  = '0;
    end else begin
      m_cnt++;
      e.valid = 1'b1;
      e.data  = d;
      e.last  = (m_cnt == m_lens[0]);
      if (e.last) begin
        void'(m_lens.pop_front());
        m_cnt = 0;
      end
    end
    rd_sb.push_back(e);
    settle();
    e = rd_sb.pop_front();
    chk("rd_valid", rd_valid, e.valid);
    chk("rd_last", rd_last, e.last);
    if (e.valid) chk("rd_data", rd_data, e.data);
    obs_last = rd_last;
    tick();
    local_rdata_valid = 1'b0;
    local_rdata_error = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       l;
    logic [4:0] lasts;
    int         n_last;
    logic [15:0] exp_err;

    phy_reset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; wr_be = '0;
    local_ready = 1'b0; local_init_done = 1'b0;
    local_rdata_valid = 1'b0; local_rdata_error = 1'b0; local_rdata = '0;
    repeat (3) tick();

    // Reset state
    settle();
    chk("rst_read_req", local_read_req, 1'b0);
    chk("rst_write_req", local_write_req, 1'b0);
    chk("rst_burstbegin", local_burstbegin, 1'b0);
    chk("rst_address", local_address, 25'd0);
    chk("rst_size", local_size, 7'd0);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_wr_ready", wr_ready, 1'b0);
    chk("rst_rd_last", rd_last, 1'b0);
    chk("rst_err_cnt", err_cnt, 16'd0);
    phy_reset = 1'b0;
    settle();
    chk("no_init_cmd_ready", cmd_ready, 1'b0);
    local_init_done = 1'b1;
    settle();
    chk("init_cmd_ready", cmd_ready, 1'b1);
    tick();

    // Write addr 0x100 len 4, controller always ready
    local_ready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 25'h100; cmd_len = 7'd4;
    settle();
    chk("A_cmd_ready", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) wr_beat(1'b1, (i == 0), 25'h100, 7'd4);
    settle();
    chk("A_idle_wreq", local_write_req, 1'b0);
    chk("A_idle_cmd_ready", cmd_ready, 1'b1);
    wr_valid = 1'b0;
    tick();

    // Write len 2 with beat 0 stalled for 3 cycles
    local_ready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 25'h2A0; cmd_len = 7'd2;
    settle();
    chk("B_cmd_ready", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    wr_beat(1'b1, 1'b1, 25'h2A0, 7'd2);
    wr_beat(1'b0, 1'b1, 25'h2A0, 7'd2);
    wr_beat(1'b0, 1'b1, 25'h2A0, 7'd2);
    local_ready = 1'b1;
    wr_beat(1'b0, 1'b1, 25'h2A0, 7'd2);
    wr_beat(1'b1, 1'b0, 25'h2A0, 7'd2);
    wr_valid = 1'b0;
    settle();
    chk("B_idle_cmd_ready", cmd_ready, 1'b1);
    tick();

    // Zero-length commands are swallowed
    for (int w = 0; w < 2; w++) begin
      cmd_valid = 1'b1; cmd_write = w[0]; cmd_addr = 25'h3F0; cmd_len = 7'd0;
      settle();
      chk("Z_cmd_ready", cmd_ready, 1'b1);
      tick();
      cmd_valid = 1'b0;
      wr_valid = 1'b1;
      settle();
      chk("Z_write_req", local_write_req, 1'b0);
      chk("Z_read_req", local_read_req, 1'b0);
      chk("Z_burstbegin", local_burstbegin, 1'b0);
      chk("Z_still_idle", cmd_ready, 1'b1);
      wr_valid = 1'b0;
      tick();
    end

    // Two len-64 reads fill the beat budget; third read waits for a return
    issue_read(25'h400, 7'd64);
    issue_read(25'h440, 7'd64);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 25'h480; cmd_len = 7'd1;
    settle();
    chk("C_third_blocked", cmd_ready, 1'b0);
    tick();
    settle();
    chk("C_third_blocked2", cmd_ready, 1'b0);
    ret_beat(1'b0, l);
    settle();
    chk("C_third_ready", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    settle();
    chk("C_third_req", local_read_req, 1'b1);
    chk("C_third_size", local_size, 7'd1);
    chk("C_third_addr", local_address, 25'h480);
    m_lens.push_back(1);
    tick();
    for (int i = 0; i < 128; i++) ret_beat(1'b0, l);

    // Reads len 2 then len 3, returns streamed back to back
    issue_read(25'h500, 7'd2);
    issue_read(25'h510, 7'd3);
    lasts = '0;
    for (int i = 0; i < 5; i++) begin
      ret_beat(1'b0, l);
      lasts[i] = l;
    end
    chk("D_last_pattern", lasts, 5'b10010);

    // Length FIFO full at LEN_FIFO_DEPTH commands
    for (int i = 0; i < 8; i++) issue_read(25'h600 + 25'(i), 7'd1);
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_len = 7'd1;
    settle();
    chk("F_fifo_full", cmd_ready, 1'b0);
    n_last = 0;
    for (int i = 0; i < 8; i++) begin
      ret_beat(1'b0, l);
      if (l) n_last++;
    end
    chk("F_last_count", n_last, 8);

    // Reset in the middle of a len-8 write with reads outstanding
    issue_read(25'h040, 7'd64);
    issue_read(25'h080, 7'd64);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 25'h700; cmd_len = 7'd8;
    settle();
    chk("E_cmd_ready", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    wr_beat(1'b1, 1'b1, 25'h700, 7'd8);
    wr_beat(1'b1, 1'b0, 25'h700, 7'd8);
    wr_valid = 1'b1;
    wr_data = {$urandom, $urandom, $urandom, $urandom};
    phy_reset = 1'b1;
    tick();
    phy_reset = 1'b0;
    m_lens.delete();
    m_cnt = 0;
    wr_sb.delete();
    cmd_write = 1'b0; cmd_len = 7'd1;
    settle();
    chk("E_write_req", local_write_req, 1'b0);
    chk("E_read_req", local_read_req, 1'b0);
    chk("E_burstbegin", local_burstbegin, 1'b0);
    chk("E_address", local_address, 25'd0);
    chk("E_size", local_size, 7'd0);
    chk("E_wdata", local_wdata, 128'd0);
    chk("E_be", local_be, 16'd0);
    chk("E_wr_ready", wr_ready, 1'b0);
    chk("E_rd_last", rd_last, 1'b0);
    chk("E_err_cnt", err_cnt, 16'd0);
    chk("E_idle_outstanding_clear", cmd_ready, 1'b1);
    tick();
    settle();
    chk("E_abandoned", local_write_req, 1'b0);
    wr_valid = 1'b0;
    ret_beat(1'b0, l);

    // Read-error counting
    for (int i = 0; i < 3; i++) ret_beat(1'b1, l);
    settle();
`ifdef DDR3_BURST_MASTER_ERRCNT_EN
    exp_err = 16'd3;
`else
    exp_err = 16'd0;
`endif
    chk("G_err_cnt", err_cnt, exp_err);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
